dram_init_sequencer: RTL

//  Power-up/initialization controller for the DDR3 command PHY. Sequences RESET, CKE power-up,
//  MRS loads (MR2, MR3, MR1, MR0) and ZQCL, honouring tRESET/tCKE/tXPR/tMRD/tMOD/tZQinit.

---
 rtl/command_definition_pkg.sv | 14 +
 rtl/initialization_state_pkg.sv | 43 ++++
 rtl/userType_pkg.sv | 14 +
 rtl/init_wait_counter.sv | 28 ++
 rtl/dram_init_sequencer.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/command_definition_pkg.sv
// Command encodings understood by the DDR3 command PHY.
package command_definition_pkg;

    typedef enum logic [2:0] {
        CMD_NOP      = 3'd0,
        CMD_RESET    = 3'd1,
        CMD_POWER_UP = 3'd2,
        CMD_MRS      = 3'd3,
        CMD_ZQCAL    = 3'd4
    } command_t;

    typedef command_t cmd_t;

endpackage

// File: rtl/initialization_state_pkg.sv
// Init sequencer state encoding, plus helpers for the command and mode-register order.
package initialization_state_pkg;

    import command_definition_pkg::*;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_RESET    = 4'd1,
        ST_CKE_WAIT = 4'd2,
        ST_XPR      = 4'd3,
        ST_MRS      = 4'd4,
        ST_MRD_WAIT = 4'd5,
        ST_MOD_WAIT = 4'd6,
        ST_ZQCL     = 4'd7,
        ST_ZQ_WAIT  = 4'd8,
        ST_DONE     = 4'd9
    } init_state_t;

    // JEDEC load order: MR2, MR3, MR1, MR0
    function automatic logic [1:0] mr_seq(input logic [1:0] idx);
        logic [1:0] mr;
        case (idx)
            2'd0:    mr = 2'd2;
            2'd1:    mr = 2'd3;
            2'd2:    mr = 2'd1;
            default: mr = 2'd0;
        endcase
        return mr;
    endfunction

    function automatic cmd_t state_command(input init_state_t s);
        cmd_t c;
        case (s)
            ST_IDLE, ST_RESET: c = CMD_RESET;
            ST_CKE_WAIT:       c = CMD_POWER_UP;
            ST_MRS:            c = CMD_MRS;
            ST_ZQCL:           c = CMD_ZQCAL;
            default:           c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/userType_pkg.sv
// Shared user types and default DDR3 initialization timing.
// The PHY, the scheduler and the init sequencer all use these defaults, so they agree on timing.
package userType_pkg;

    // Cycle counts at 400 MHz
    localparam int unsigned T_RESET_CYC_DEF  = 80000;
    localparam int unsigned T_CKE_CYC_DEF    = 200000;
    localparam int unsigned T_XPR_CYC_DEF    = 108;
    localparam int unsigned T_MRD_CYC_DEF    = 4;
    localparam int unsigned T_MOD_CYC_DEF    = 12;
    localparam int unsigned T_ZQINIT_CYC_DEF = 512;
    localparam int unsigned CNT_W_DEF        = 18;

endpackage

// File: rtl/init_wait_counter.sv
// Down-counter used for every init wait interval.
// It saturates at zero, and a load takes priority over a decrement.
module init_wait_counter #(
    parameter int unsigned CNT_W = 18
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dram_init_sequencer.sv
// DDR3 power-up sequencer: RESET, CKE, NOP (tXPR), MR2/MR3/MR1/MR0 loads, ZQCL, then done.
// Outputs are decoded from the next state and registered, so o_command always matches o_state.
module dram_init_sequencer
    import userType_pkg::*;
    import command_definition_pkg::*;
    import initialization_state_pkg::*;
#(
    parameter int unsigned T_RESET_CYC  = T_RESET_CYC_DEF,
    parameter int unsigned T_CKE_CYC    = T_CKE_CYC_DEF,
    parameter int unsigned T_XPR_CYC    = T_XPR_CYC_DEF,
    parameter int unsigned T_MRD_CYC    = T_MRD_CYC_DEF,
    parameter int unsigned T_MOD_CYC    = T_MOD_CYC_DEF,
    parameter int unsigned T_ZQINIT_CYC = T_ZQINIT_CYC_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        i_start,
    output cmd_t        o_command,
    output logic [1:0]  o_mode_register_num,
    output logic        o_busy,
    output logic        o_init_done,
    output init_state_t o_state
);

    // MRS and ZQCL are single-cycle states, so their following waits load two less than the spacing
    localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(T_XPR_CYC - 1);
    localparam logic [CNT_W-1:0] LD_MRD   = (T_MRD_CYC > 1)    ? CNT_W'(T_MRD_CYC - 2)    : '0;
    localparam logic [CNT_W-1:0] LD_MOD   = (T_MOD_CYC > 1)    ? CNT_W'(T_MOD_CYC - 2)    : '0;
    localparam logic [CNT_W-1:0] LD_ZQ    = (T_ZQINIT_CYC > 1) ? CNT_W'(T_ZQINIT_CYC - 2) : '0;

    init_state_t      state;
    init_state_t      next_state;
    logic [1:0]       mr_idx;
    logic [1:0]       mr_idx_next;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_zero;

    init_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_comb begin
        next_state  = state;
        mr_idx_next = mr_idx;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_value   = '0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = ST_RESET;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_RESET;
                end
            end
            ST_RESET: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_CKE_WAIT;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_CKE;
                end
            end
            ST_CKE_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_XPR;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_XPR;
                end
            end
            ST_XPR: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    next_state  = ST_MRS;
                    mr_idx_next = 2'd0;
                end
            end
            ST_MRS: begin
                // A spacing of 1 goes straight to the next command with no wait state
                if (mr_idx != 2'd3) begin
                    if (T_MRD_CYC > 1) begin
                        next_state = ST_MRD_WAIT;
                        cnt_load   = 1'b1;
                        cnt_value  = LD_MRD;
                    end else begin
                        next_state  = ST_MRS;
                        mr_idx_next = mr_idx + 2'd1;
                    end
                end else if (T_MOD_CYC > 1) begin
                    next_state = ST_MOD_WAIT;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_MOD;
                end else begin
                    next_state = ST_ZQCL;
                end
            end
            ST_MRD_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    next_state  = ST_MRS;
                    mr_idx_next = mr_idx + 2'd1;
                end
            end
            ST_MOD_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_ZQCL;
                end
            end
            ST_ZQCL: begin
                if (T_ZQINIT_CYC > 1) begin
                    next_state = ST_ZQ_WAIT;
                    cnt_load   = 1'b1;
                    cnt_value  = LD_ZQ;
                end else begin
                    next_state = ST_DONE;
                end
            end
            ST_ZQ_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_DONE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            mr_idx              <= 2'd0;
            o_command           <= CMD_RESET;
            o_mode_register_num <= 2'd0;
            o_busy              <= 1'b0;
            o_init_done         <= 1'b0;
        end else begin
            state       <= next_state;
            mr_idx      <= mr_idx_next;
            o_command   <= state_command(next_state);
            o_busy      <= (next_state != ST_IDLE) && (next_state != ST_DONE);
            o_init_done <= (next_state == ST_DONE);
            if (next_state == ST_MRS) begin
                o_mode_register_num <= mr_seq(mr_idx_next);
            end
        end
    end

    assign o_state = state;

endmodule
